// File: rtl/txn_chk_pkg.sv
// Shared types for the transaction event-window checker: result codes,
// channel states and the range evaluation helper.
package txn_chk_pkg;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_UNDER   = 3'd1,
        ERR_OVER    = 3'd2,
        ERR_EMPTY   = 3'd3,
        ERR_OVERLAP = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_e;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_e;

    // Operands are zero-extended by the caller so one helper serves any counter width.
    function automatic err_e eval_range(input logic [31:0] cnt,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        err_e res;
        if (cnt < lo) begin
            res = ERR_UNDER;
        end else if (cnt > hi) begin
            res = ERR_OVER;
        end else begin
            res = ERR_OK;
        end
        return res;
    endfunction

endpackage

// File: rtl/txn_chk_channel.sv
// One checker channel: edge detection, IDLE/OPEN window FSM, saturating
// event counter, window timer and registered result.
module txn_chk_channel
    import txn_chk_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             evt,
    input  logic [CNT_W-1:0] exp_min,
    input  logic [CNT_W-1:0] exp_max,
    input  logic [TMO_W-1:0] timeout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output err_e             err,
    output logic [CNT_W-1:0] count,
    output logic             fail_evt
);

    localparam int PAD_W = 32 - CNT_W;

    state_e           state_r, state_nx_s;
    logic             start_q_r, stop_q_r;
    logic [CNT_W-1:0] cnt_r, min_r, max_r, res_cnt_r;
    logic [TMO_W-1:0] tmr_r, tmo_r;
    logic             done_r, pass_r;
    err_e             err_r;

    logic             start_rise_s, stop_rise_s, tmo_hit_s;
    logic [CNT_W-1:0] cnt_init_s, cnt_inc_s, close_cnt_s;
    logic             load_s, close_s;
    err_e             close_err_s;

    assign start_rise_s = start & ~start_q_r;
    assign stop_rise_s  = stop & ~stop_q_r;
    assign cnt_init_s   = {{(CNT_W-1){1'b0}}, evt};
    assign cnt_inc_s    = (evt && (cnt_r != {CNT_W{1'b1}}))
                          ? cnt_r + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_r;
    // The timer holds the number of window cycles already elapsed.
    assign tmo_hit_s    = (tmo_r != {TMO_W{1'b0}}) && (tmr_r == tmo_r);

    // Next state and close decision; overlap beats stop, stop beats timeout.
    always_comb begin
        state_nx_s  = state_r;
        load_s      = 1'b0;
        close_s     = 1'b0;
        close_err_s = ERR_OK;
        close_cnt_s = cnt_inc_s;
        case (state_r)
            IDLE: begin
                if (start_rise_s && stop_rise_s) begin
                    close_s     = 1'b1;
                    close_err_s = ERR_EMPTY;
                    close_cnt_s = cnt_init_s;
                end else if (start_rise_s) begin
                    state_nx_s = OPEN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OPEN: begin
                if (start_rise_s) begin
                    close_s     = 1'b1;
                    close_err_s = ERR_OVERLAP;
                    close_cnt_s = cnt_r;
                    load_s      = 1'b1;
                end else if (stop_rise_s) begin
                    close_s     = 1'b1;
                    state_nx_s  = IDLE;
                    close_err_s = eval_range({{PAD_W{1'b0}}, cnt_inc_s},
                                             {{PAD_W{1'b0}}, min_r},
                                             {{PAD_W{1'b0}}, max_r});
                end else if (tmo_hit_s) begin
                    close_s     = 1'b1;
                    state_nx_s  = IDLE;
                    close_err_s = ERR_TIMEOUT;
                end else begin
                    state_nx_s = OPEN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    assign fail_evt = close_s && (close_err_s != ERR_OK);

    // State, edge history, window counters and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            start_q_r <= 1'b0;
            stop_q_r  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            tmr_r     <= {TMO_W{1'b0}};
            min_r     <= {CNT_W{1'b0}};
            max_r     <= {CNT_W{1'b0}};
            tmo_r     <= {TMO_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            start_q_r <= start;
            stop_q_r  <= stop;
            if (load_s) begin
                cnt_r <= cnt_init_s;
                tmr_r <= {{(TMO_W-1){1'b0}}, 1'b1};
                min_r <= exp_min;
                max_r <= exp_max;
                tmo_r <= timeout;
            end else if (state_r == OPEN) begin
                cnt_r <= cnt_inc_s;
                tmr_r <= tmr_r + {{(TMO_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
                tmr_r <= tmr_r;
            end
        end
    end

    // Result registers: done pulses for one cycle, the rest hold until the next close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_r     <= ERR_OK;
            res_cnt_r <= {CNT_W{1'b0}};
        end else begin
            done_r <= close_s;
            if (close_s) begin
                pass_r    <= (close_err_s == ERR_OK);
                err_r     <= close_err_s;
                res_cnt_r <= close_cnt_s;
            end else begin
                pass_r    <= pass_r;
                err_r     <= err_r;
                res_cnt_r <= res_cnt_r;
            end
        end
    end

    assign busy  = (state_r == OPEN);
    assign done  = done_r;
    assign pass  = pass_r;
    assign err   = err_r;
    assign count = res_cnt_r;

endmodule

// File: rtl/txn_event_window_checker.sv
// Multi-channel event-window checker: NUM_CH independent channels plus a
// sticky failure flag that is cleared only by reset.
module txn_event_window_checker
    import txn_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int TMO_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       stop_i,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [CNT_W-1:0]        exp_min_i,
    input  logic [CNT_W-1:0]        exp_max_i,
    input  logic [TMO_W-1:0]        timeout_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH*3-1:0]     err_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    fail_sticky_o
);

    logic [NUM_CH-1:0] fail_evt_s;
    logic              fail_sticky_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        txn_chk_channel #(
            .CNT_W(CNT_W),
            .TMO_W(TMO_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_i[g]),
            .stop     (stop_i[g]),
            .evt      (event_i[g]),
            .exp_min  (exp_min_i),
            .exp_max  (exp_max_i),
            .timeout  (timeout_i),
            .busy     (busy_o[g]),
            .done     (done_o[g]),
            .pass     (pass_o[g]),
            .err      (err_o[g*3 +: 3]),
            .count    (count_o[g*CNT_W +: CNT_W]),
            .fail_evt (fail_evt_s[g])
        );
    end

    // Fed from the pre-register close decision so it rises together with done_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_sticky_r <= 1'b0;
        end else begin
            fail_sticky_r <= fail_sticky_r | (|fail_evt_s);
        end
    end

    assign fail_sticky_o = fail_sticky_r;

endmodule

// File: doc/txn_event_window_checker.md
Name: txn_event_window_checker

Overview:
- Synthesizable, multi-channel successor to our property-style "N non-consecutive events between start and end" check.
- Each channel opens a window on a rising edge of its start input and closes it on a rising edge of its stop input.
- While the window is open, the channel counts the cycles in which its event input is high. It then checks the count against a runtime [min,max] range and reports pass/fail with an error code.
- Instantiated alongside CPU/bus interfaces as an always-on transaction monitor. Results go to scoreboards and to a sticky error status.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 8, width of the event counter and of the expected-range inputs.
- TMO_W, 16, width of the timeout counter and of the timeout input.

Ports:
- clk  in  1  sampling clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  NUM_CH  per-channel window-open request; acts on its rising edge.
- stop_i  in  NUM_CH  per-channel window-close request; acts on its rising edge.
- event_i  in  NUM_CH  per-channel event; counted on every cycle it is high inside the window.
- exp_min_i  in  CNT_W  minimum legal count, shared by all channels, sampled at window open.
- exp_max_i  in  CNT_W  maximum legal count, sampled at window open.
- timeout_i  in  TMO_W  maximum window length in cycles; 0 disables the timeout; sampled at window open.
- busy_o  out  NUM_CH  window currently open.
- done_o  out  NUM_CH  one-cycle result-valid pulse.
- pass_o  out  NUM_CH  result is OK; meaningful only when done_o is high.
- err_o  out  NUM_CH*3  per-channel error code (txn_chk_pkg::err_e); holds its value until the next done_o.
- count_o  out  NUM_CH*CNT_W  final count of the last closed window.
- fail_sticky_o  out  1  OR of all failures since reset.

Behaviour:
- Reset values: every output is 0 (err_o = ERR_OK). Internal edge-detect history registers reset to 0, so an input already high on the first cycle after reset counts as a rise. Reset asserted mid-window discards the window with no done_o.
- Edge detection: rise(x) = x & ~x_q, with x_q registered every cycle.
- Per-channel state machine, two states, IDLE and OPEN:
  - IDLE -> OPEN on rise(start). The count is loaded with event_i of that same cycle, so the start cycle counts. min, max and timeout are latched in that cycle.
  - OPEN: count increments each cycle event_i is high and saturates at 2^CNT_W-1. The timer increments each cycle.
  - OPEN -> IDLE on rise(stop). An event in the stop cycle is counted. Result:
    - count < min gives ERR_UNDER.
    - count > max gives ERR_OVER.
    - otherwise ERR_OK.
  - Result latency: done_o, pass_o, err_o and count_o are registered and appear exactly 1 cycle after the closing cycle.
- Boundary cases:
  - rise(start) and rise(stop) in the same cycle while IDLE: report ERR_EMPTY on the next cycle with count = event_i. The window stays closed, because the stop must arrive at least one cycle after the start.
  - rise(start) while OPEN: close the current window with ERR_OVERLAP, and in the same cycle open a fresh window counting from this cycle. Overlap takes priority over a simultaneous rise(stop).
  - Timeout: if timeout != 0 and the timer reaches timeout while no rise(stop) arrives, close the window with ERR_TIMEOUT.
  - A stop that arrives on the same cycle as the timeout wins, giving a normal evaluation.
  - rise(stop) while IDLE is ignored.
  - Config with min > max: every window fails with ERR_OVER or ERR_UNDER; this is not flagged separately.
- fail_sticky_o is set by any done_o with pass_o = 0 and is cleared only by reset.

Decomposition:
- txn_chk_pkg holds:
  - the err_e enum (3 bits): ERR_OK=0, ERR_UNDER=1, ERR_OVER=2, ERR_EMPTY=3, ERR_OVERLAP=4, ERR_TIMEOUT=5;
  - the state_e enum (IDLE, OPEN).
- Sub-module txn_chk_channel contains one channel's edge detect, state machine, counter, timer and result registers. The top level instantiates it NUM_CH times in a generate loop and ORs the channel failures into fail_sticky_o.

Test Plan:
- Ch0: rise(start) at cycle 1; event high at cycles 4, 7, 9; rise(stop) at cycle 9; min = max = 3 -> done_o[0] at cycle 10, pass = 1, err = OK, count = 3.
- Same stimulus with min = max = 2 -> err = OVER, count = 3, fail_sticky_o = 1 from cycle 10 onward.
- Ch1: start at cycle 2, one event, stop at cycle 6, min = 2, max = 5 -> err = UNDER, count = 1. Meanwhile ch2 runs a concurrent independent passing window -> both done_o pulses are correct and independent.
- Ch0: start and stop rise together at cycle 3 -> err = EMPTY at cycle 4, busy_o[0] never set.
- Ch0: start at cycle 1, second rise(start) at cycle 5 with 2 events between them -> OVERLAP result at cycle 6 with count = 2. The new window then closes normally at stop cycle 8.
- timeout = 10: start at cycle 0 with no stop -> TIMEOUT done pulse at cycle 11. Reset asserted mid-window on a second attempt -> all outputs 0 and no done_o.
